// File: rtl/fedriver_rstseq_pkg.sv
// Shared types and default timing constants for the front-end driver reset sequencer.
package libfedriver;

  typedef enum logic [1:0] {
    RS_HOLD     = 2'd0,
    RS_WAITLOCK = 2'd1,
    RS_RELEASE  = 2'd2,
    RS_RUN      = 2'd3
  } fedriver_rstseq_state_type;

  localparam int unsigned RSTSEQ_HOLD = 16;
  localparam int unsigned RSTSEQ_FILT = 4;
  localparam int unsigned RSTSEQ_GAP  = 8;

endpackage

// File: rtl/fedriver_rstseq_sync2.sv
// Parameterised-width two-flop synchroniser with asynchronous active-low clear.
module fedriver_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fedriver_rstseq.sv
// Reset sequencer: qualifies lock/external reset, holds, filters, then releases
// NCH channel resets in order with a fixed gap; supports handshaked soft reset.
module fedriver_rstseq
  import libfedriver::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned NLOCK       = 2,
  parameter int unsigned HOLD_CYCLES = RSTSEQ_HOLD,
  parameter int unsigned LOCK_FILT   = RSTSEQ_FILT,
  parameter int unsigned GAP_CYCLES  = RSTSEQ_GAP
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NLOCK-1:0] lock,
  input  logic             ext_rst,
  input  logic             soft_req,
  output logic             soft_ack,
  output logic [NCH-1:0]   ch_rst,
  output logic             all_ready,
  output logic [1:0]       state
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned FW = $clog2(LOCK_FILT + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned IW = $clog2(NCH + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NCH - 1);

  logic [NLOCK-1:0] lock_s;
  logic             ext_s;
  logic             ok;

  fedriver_sync2 #(.WIDTH(NLOCK)) u_sync_lock (
    .clk  (clk),
    .rstn (rstn),
    .d    (lock),
    .q    (lock_s)
  );

  fedriver_sync2 #(.WIDTH(1)) u_sync_ext (
    .clk  (clk),
    .rstn (rstn),
    .d    (ext_rst),
    .q    (ext_s)
  );

  assign ok = (&lock_s) & ~ext_s;

  fedriver_rstseq_state_type state_q, state_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [FW-1:0]  filt_q, filt_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [NCH-1:0] ch_rst_q, ch_rst_d;
  logic           ready_q, ready_d;
  logic           ack_q, ack_d;
  logic           abort;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= RS_HOLD;
      hold_q   <= '0;
      filt_q   <= '0;
      gap_q    <= '0;
      idx_q    <= '0;
      ch_rst_q <= '1;
      ready_q  <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      filt_q   <= filt_d;
      gap_q    <= gap_d;
      idx_q    <= idx_d;
      ch_rst_q <= ch_rst_d;
      ready_q  <= ready_d;
      ack_q    <= ack_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    filt_d   = filt_q;
    gap_d    = gap_q;
    idx_d    = idx_q;
    ch_rst_d = ch_rst_q;
    ready_d  = ready_q;
    ack_d    = 1'b0;
    abort    = 1'b0;

    unique case (state_q)
      RS_HOLD: begin
        hold_d = hold_q + HW'(1);
        if (hold_q == HOLD_LAST) state_d = RS_WAITLOCK;
      end
      RS_WAITLOCK: begin
        if (!ok) begin
          filt_d = '0;
        end else if (filt_q == FILT_LAST) begin
          ch_rst_d[0] = 1'b0;
          idx_d       = IW'(1);
          gap_d       = '0;
          if (NCH == 1) begin
            state_d = RS_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = RS_RELEASE;
          end
        end else begin
          filt_d = filt_q + FW'(1);
        end
      end
      RS_RELEASE: begin
        if (!ok) begin
          abort = 1'b1;
        end else if (gap_q == GAP_LAST) begin
          for (int unsigned i = 0; i < NCH; i++) begin
            if (idx_q == IW'(i)) ch_rst_d[i] = 1'b0;
          end
          idx_d = idx_q + IW'(1);
          gap_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = RS_RUN;
            ready_d = 1'b1;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      RS_RUN: begin
        // Lock loss outranks a soft request: abort without acknowledging it.
        if (!ok) begin
          abort = 1'b1;
        end else if (soft_req) begin
          abort = 1'b1;
          ack_d = 1'b1;
        end
      end
      default: state_d = RS_HOLD;
    endcase

    if (abort) begin
      state_d  = RS_HOLD;
      hold_d   = '0;
      filt_d   = '0;
      gap_d    = '0;
      idx_d    = '0;
      ch_rst_d = '1;
      ready_d  = 1'b0;
    end
  end

  assign ch_rst    = ch_rst_q;
  assign all_ready = ready_q;
  assign soft_ack  = ack_q;
  assign state     = state_q;

endmodule

// File: doc/fedriver_rstseq.md
# fedriver_rstseq

Parametrised reset sequencer for the front-end driver clock domain. It is the successor to the single-output `rst | ~locked` scheme. It qualifies several asynchronous lock indicators and an external reset, and enforces a minimum reset hold. It releases `NCH` reset channels in a fixed order with a programmable gap, and supports a handshaked soft reset. It sits directly after the clock generator and feeds per-subsystem resets (DMA, MAC, CPU pipeline, ...).

## Interface
Parameters:
- `NCH`, 4: number of reset channels, ≥1.
- `NLOCK`, 2: number of lock inputs, ≥1.
- `HOLD_CYCLES`, 16: minimum cycles in HOLD, ≥1.
- `LOCK_FILT`, 4: consecutive qualified cycles required before release, ≥1.
- `GAP_CYCLES`, 8: cycles between successive channel releases, ≥1.

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rstn`, in, 1: asynchronous, active-low reset.
- `lock`, in, `NLOCK`: DCM/PLL lock flags; asynchronous, passed through 2-flop synchronisers.
- `ext_rst`, in, 1: asynchronous external reset, active-high; passed through a 2-flop synchroniser.
- `soft_req`, in, 1: level soft-reset request, synchronous.
- `soft_ack`, out, 1: one-cycle pulse when a soft reset is accepted.
- `ch_rst`, out, `NCH`: per-channel reset, active-high.
- `all_ready`, out, 1: high when all channels are released.
- `state`, out, 2: FSM state, for debug.

## Operation
- **Qualification.** `ok` = (all synced `lock` = 1) and (synced `ext_rst` = 0).
- **HOLD.**
  - `hold_cnt` increments every cycle.
  - When `hold_cnt` = `HOLD_CYCLES`-1, the FSM moves to WAITLOCK.
  - All `ch_rst` bits are 1.
- **WAITLOCK.**
  - `filt_cnt` increments when `ok` is high and clears to 0 otherwise.
  - When `filt_cnt` reaches `LOCK_FILT`-1 while `ok` is high, the FSM moves to RELEASE.
  - On that same edge, `ch_rst[0]` goes to 0, `idx` is set to 1 and `gap_cnt` is set to 0.
- **RELEASE.**
  - `gap_cnt` counts cycles.
  - On the edge where it reaches `GAP_CYCLES`-1: `ch_rst[idx]` goes to 0, `idx` increments and `gap_cnt` clears.
  - When the last channel (`NCH`-1) is released, the FSM moves to RUN and `all_ready` goes to 1 on the same edge.
  - If `NCH` = 1, the FSM goes straight from WAITLOCK to RUN and `all_ready` rises on the edge that releases `ch_rst[0]`.
- **RUN.**
  - Outputs are held.
  - `soft_req` is sampled only in this state.
- **Abort.** If `ok` goes low in RELEASE or RUN, the next edge sets all `ch_rst` to 1, `all_ready` to 0, the state to HOLD and all counters to 0.
- **Soft reset.**
  - If `soft_req` = 1 in RUN and `ok` = 1, the next edge does the same abort and also sets `soft_ack` = 1 for exactly one cycle.
  - The requester must drop `soft_req` after `soft_ack`. A request that is still held re-triggers on the next RUN.
- **Priority.**
  - Loss of `ok` beats `soft_req`. If both occur in the same cycle, the abort happens with `soft_ack` = 0.
  - A request still held is then served on the next RUN.
- **Counter widths.** Each counter is `$clog2(max+1)` bits, with no wrap. Each counter saturates or clears only as described above.

## Timing
- **Reset values** (while `rstn` = 0, asynchronous):
  - `ch_rst` = all ones, `all_ready` = 0, `soft_ack` = 0.
  - `state` = HOLD (2'd0); the encoding is HOLD = 0, WAITLOCK = 1, RELEASE = 2, RUN = 3.
  - Counters and synchroniser flops are 0.
- **Reset mid-sequence.** Asserting `rstn` at any time forces the reset values immediately, regardless of state.
- **Lock loss latency.** A `lock` bit falling at the input causes `ch_rst` to reach all ones by the 3rd rising edge (2 synchroniser edges + 1 register).
- **Release schedule.** With `ok` already stable high, `ch_rst[k]` falls at edge `HOLD_CYCLES + LOCK_FILT + k*GAP_CYCLES` after `rstn` deasserts. This holds provided `HOLD_CYCLES` ≥ 2, so the synchronisers fill during HOLD.
- **Output registers.** All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- **Package `libfedriver`.** Add `typedef enum bit [1:0] {RS_HOLD, RS_WAITLOCK, RS_RELEASE, RS_RUN} fedriver_rstseq_state_type;` there, plus the default constants `RSTSEQ_HOLD`, `RSTSEQ_FILT` and `RSTSEQ_GAP`.
- **Sub-module `fedriver_sync2`.** A parameterised-width 2-flop synchroniser with async active-low clear. It is instantiated once for `lock` and once for `ext_rst`.
- The FSM, counters and `ch_rst` register live in `fedriver_rstseq`.

## Test plan
Defaults throughout: `NCH`=4, `HOLD_CYCLES`=16, `LOCK_FILT`=4, `GAP_CYCLES`=8.
1. `lock` = 2'b11, `ext_rst` = 0, `rstn` released at edge 0 -> `ch_rst` goes 1111 → 1110 at edge 20, 1100 at 28, 1000 at 36, 0000 at 44; `all_ready` = 1 at 44; `state` = 3.
2. In RUN, `lock[1]` dropped for one cycle -> `ch_rst` = 1111 and `all_ready` = 0 within 3 edges; `state` = 0; the full release sequence then repeats 20 edges later.
3. In WAITLOCK, `lock[0]` glitches low for 1 cycle at `filt_cnt` = 2 -> filter restarts; `ch_rst[0]` falls 4 qualified cycles after the glitch clears.
4. In RUN, `soft_req` = 1 -> `soft_ack` is a single-cycle pulse on the next edge, `ch_rst` = 1111, `state` = 0; `soft_req` dropped after the ack -> normal re-release with no second ack.
5. In RUN, `soft_req` = 1 in the same cycle `ok` falls -> abort with `soft_ack` = 0; `soft_req` still held -> `soft_ack` = 1 on the first RUN cycle afterwards.
6. `rstn` asserted in RELEASE after `ch_rst` = 1100 -> `ch_rst` = 1111 asynchronously, before the next edge; `all_ready` = 0; `soft_ack` = 0.
